// File: rtl/seq_alu_param_if.sv
// Bus between the control unit / register-file muxes and seq_alu_param.
// The control unit uses the master modport; the ALU uses the slave modport.
interface seq_alu_param_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [5:0]       FunSel;
    logic             WF;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ALUOut;
    logic [3:0]       FlagsOut;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, FunSel, WF, A, B,
        input  ALUOut, FlagsOut, Busy, Done
    );

    modport slave (
        input  Start, FunSel, WF, A, B,
        output ALUOut, FlagsOut, Busy, Done
    );
endinterface

// File: rtl/seq_alu_param.sv
// Registered ALU: 16 single-cycle ops plus iterative MUL/MULH; DIVU/REMU are
// built only when SEQ_ALU_DIV_EN is defined (otherwise ops 18/19 are reserved).
//
// state  | meaning
// S_IDLE | accepts Start; single-cycle and reserved ops complete here
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle (SEQ_ALU_DIV_EN only)
module seq_alu_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic           Clock,
    input logic           Reset,
    seq_alu_param_if.slave bus
);
    localparam int HW  = WIDTH / 2;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             wf_q, wf_d;
    logic             sel_q, sel_d;
`ifdef SEQ_ALU_DIV_EN
    logic             dz_q, dz_d;
`endif

    logic [4:0]       op;
    logic             narrow;
    logic             is_mul;
    logic             is_div;
    logic             last;
    logic [WIDTH-1:0] x_op, y_op, alu_r;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_o, set_c, set_o, cin;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   r_sh, r_sub;
    logic             q_bit;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;
`endif

    assign op     = bus.FunSel[4:0];
    assign narrow = bus.FunSel[5];
    assign is_mul = (op == 5'd16) || (op == 5'd17);
`ifdef SEQ_ALU_DIV_EN
    assign is_div = (op == 5'd18) || (op == 5'd19);
`else
    assign is_div = 1'b0;
`endif
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));
    assign cin    = flags_q[2];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            flags_q <= 4'b0000;
            done_q  <= 1'b0;
            wf_q    <= 1'b0;
            sel_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            wf_q    <= wf_d;
            sel_q   <= sel_d;
`ifdef SEQ_ALU_DIV_EN
            dz_q    <= dz_d;
`endif
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    if (is_mul)      state_d = S_MUL;
                    else if (is_div) state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: if (last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle ALU on the live bus operands (captured by the Start edge).
    always_comb begin : alu
        x_op  = narrow ? {{HW{bus.A[HW-1]}}, bus.A[HW-1:0]} : bus.A;
        y_op  = narrow ? {{HW{bus.B[HW-1]}}, bus.B[HW-1:0]} : bus.B;
        alu_r = '0;
        alu_c = 1'b0;
        alu_o = 1'b0;
        set_c = 1'b0;
        set_o = 1'b0;
        sum   = '0;
        case (op[3:0])
            4'd0:  alu_r = x_op;
            4'd1:  alu_r = y_op;
            4'd2:  alu_r = ~x_op;
            4'd3:  alu_r = ~y_op;
            4'd4, 4'd5: begin
                sum   = {1'b0, x_op} + {1'b0, y_op}
                        + {{WIDTH{1'b0}}, (op[3:0] == 4'd5) & cin};
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_o = (x_op[MSB] == y_op[MSB]) && (alu_r[MSB] != x_op[MSB]);
                set_c = 1'b1;
                set_o = 1'b1;
            end
            4'd6: begin
                // The extra top bit of the difference is the unsigned borrow.
                sum   = {1'b0, x_op} - {1'b0, y_op};
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_o = (x_op[MSB] != y_op[MSB]) && (alu_r[MSB] == y_op[MSB]);
                set_c = 1'b1;
                set_o = 1'b1;
            end
            4'd7:  alu_r = x_op & y_op;
            4'd8:  alu_r = x_op | y_op;
            4'd9:  alu_r = x_op ^ y_op;
            4'd10: alu_r = ~(x_op & y_op);
            4'd11: begin alu_r = {x_op[MSB-1:0], 1'b0};      alu_c = x_op[MSB]; set_c = 1'b1; end
            4'd12: begin alu_r = {1'b0, x_op[MSB:1]};        alu_c = x_op[0];   set_c = 1'b1; end
            4'd13: begin alu_r = {x_op[MSB], x_op[MSB:1]};   alu_c = x_op[0];   set_c = 1'b1; end
            4'd14: begin alu_r = {x_op[MSB-1:0], cin};       alu_c = x_op[MSB]; set_c = 1'b1; end
            default: begin alu_r = {cin, x_op[MSB:1]};       alu_c = x_op[0];   set_c = 1'b1; end
        endcase
    end

    // One iteration step; {hi,lo} is the product/remainder:quotient pair.
    always_comb begin : iter
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_q[MSB:1]};
`ifdef SEQ_ALU_DIV_EN
        r_sh     = {hi_q, lo_q[MSB]};
        r_sub    = r_sh - {1'b0, opnd_q};
        q_bit    = ~r_sub[WIDTH];
        div_hi_n = q_bit ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
        div_lo_n = {lo_q[MSB-1:0], q_bit};
`endif
    end

    always_comb begin : update
        cnt_d   = cnt_q;
        res_d   = res_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        wf_d    = wf_q;
        sel_d   = sel_q;
`ifdef SEQ_ALU_DIV_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    wf_d  = bus.WF;
                    cnt_d = '0;
                    sel_d = op[0];
                    hi_d  = '0;
                    if (is_mul) begin
                        opnd_d = bus.A;
                        lo_d   = bus.B;
                    end else if (is_div) begin
                        opnd_d = bus.B;
                        lo_d   = bus.A;
`ifdef SEQ_ALU_DIV_EN
                        dz_d   = (bus.B == '0);
`endif
                    end else if (!op[4]) begin
                        done_d = 1'b1;
                        res_d  = alu_r;
                        if (bus.WF) begin
                            flags_d[3] = (alu_r == '0);
                            flags_d[1] = alu_r[MSB];
                            if (set_c) flags_d[2] = alu_c;
                            if (set_o) flags_d[0] = alu_o;
                        end
                    end else begin
                        done_d = 1'b1;
                        res_d  = '0;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                if (last) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    res_d  = sel_q ? mul_hi_n : mul_lo_n;
                    if (wf_q) begin
                        flags_d[3] = (res_d == '0);
                        flags_d[2] = (mul_hi_n != '0);
                        flags_d[1] = res_d[MSB];
                    end
                end
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV: begin
                cnt_d = cnt_q + CNT_W'(1);
                hi_d  = div_hi_n;
                lo_d  = div_lo_n;
                if (last) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    res_d  = sel_q ? div_hi_n : div_lo_n;
                    if (wf_q) begin
                        flags_d[3] = (res_d == '0);
                        flags_d[2] = dz_q;
                        flags_d[1] = res_d[MSB];
                    end
                end
            end
`endif
            default: cnt_d = '0;
        endcase
    end

    always_comb begin : outputs
        bus.ALUOut   = res_q;
        bus.FlagsOut = flags_q;
        bus.Busy     = (state_q != S_IDLE);
        bus.Done     = done_q;
    end
endmodule

// File: tb/tb_seq_alu_param.sv
// Directed bench for seq_alu_param at WIDTH=32; divide checks follow SEQ_ALU_DIV_EN.
module tb_seq_alu_param;
    localparam int W = 32;

    typedef struct {
        logic [5:0]  fs;
        logic        wf;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   n;
    int   done_busy;

    always #5 clk = ~clk;

    seq_alu_param_if #(.WIDTH(W)) bus_if ();

    seq_alu_param #(.WIDTH(W)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus_if.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one op; returns at the negedge after the Start edge with operands scrambled.
    task automatic start_op(input logic [5:0] fs, input logic wf, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        bus_if.Start  = 1'b1;
        bus_if.FunSel = fs;
        bus_if.WF     = wf;
        bus_if.A      = a;
        bus_if.B      = b;
        @(negedge clk);
        bus_if.Start  = 1'b0;
        bus_if.FunSel = 6'd4;
        bus_if.WF     = ~wf;
        bus_if.A      = ~a;
        bus_if.B      = ~b;
    endtask

    // Runs an iterative op to completion; optionally pulses Start while busy.
    task automatic run_iter(input string name, input logic [5:0] fs, input logic wf,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_r, input logic [3:0] exp_f,
                            input bit poke);
        start_op(fs, wf, a, b);
        n = 0;
        done_busy = 0;
        while (bus_if.Busy && n < 64) begin
            if (bus_if.Done) done_busy++;
            if (poke && n == 3) bus_if.Start = 1'b1;
            @(negedge clk);
            bus_if.Start = 1'b0;
            n++;
        end
        chk({name, " busy_cycles"}, n, W);
        chk({name, " done"}, {31'd0, bus_if.Done}, 32'd1);
        chk({name, " done_with_busy"}, done_busy, 0);
        chk({name, " result"}, bus_if.ALUOut, exp_r);
        chk({name, " flags"}, {28'd0, bus_if.FlagsOut}, {28'd0, exp_f});
    endtask

    vec_t vt [23];

    initial begin
        vt[0]  = '{6'd4,  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100};
        vt[1]  = '{6'd5,  1'b1, 32'h00000001, 32'h00000001, 32'h00000003, 4'b0000};
        vt[2]  = '{6'd5,  1'b1, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000};
        vt[3]  = '{6'd4,  1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011};
        vt[4]  = '{6'h26, 1'b1, 32'h00008000, 32'h00000001, 32'hFFFF7FFF, 4'b0010};
        vt[5]  = '{6'd6,  1'b1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0110};
        vt[6]  = '{6'd14, 1'b1, 32'h80000001, 32'h00000000, 32'h00000003, 4'b0100};
        vt[7]  = '{6'd15, 1'b1, 32'h00000002, 32'h00000000, 32'h80000001, 4'b0010};
        vt[8]  = '{6'd11, 1'b0, 32'h80000000, 32'h00000000, 32'h00000000, 4'b0010};
        vt[9]  = '{6'd12, 1'b1, 32'h00000003, 32'h00000000, 32'h00000001, 4'b0100};
        vt[10] = '{6'd13, 1'b1, 32'h80000002, 32'h00000000, 32'hC0000001, 4'b0010};
        vt[11] = '{6'd7,  1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010};
        vt[12] = '{6'd8,  1'b1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
        vt[13] = '{6'd9,  1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b1000};
        vt[14] = '{6'd10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
        vt[15] = '{6'd0,  1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 4'b0000};
        vt[16] = '{6'd1,  1'b1, 32'h00000000, 32'h9ABCDEF0, 32'h9ABCDEF0, 4'b0010};
        vt[17] = '{6'd2,  1'b1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0010};
        vt[18] = '{6'd3,  1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
        vt[19] = '{6'h20, 1'b1, 32'h12345678, 32'h00000000, 32'h00005678, 4'b0000};
        vt[20] = '{6'h21, 1'b1, 32'h00000000, 32'h00008001, 32'hFFFF8001, 4'b0010};
        vt[21] = '{6'd25, 1'b1, 32'h11111111, 32'h22222222, 32'h00000000, 4'b0010};
        vt[22] = '{6'h24, 1'b1, 32'h00007FFF, 32'h00000001, 32'h00008000, 4'b0000};

        rst_n         = 1'b0;
        bus_if.Start  = 1'b0;
        bus_if.FunSel = 6'd0;
        bus_if.WF     = 1'b0;
        bus_if.A      = '0;
        bus_if.B      = '0;
        #12;
        chk("reset ALUOut", bus_if.ALUOut, 32'd0);
        chk("reset FlagsOut", {28'd0, bus_if.FlagsOut}, 32'd0);
        chk("reset Busy", {31'd0, bus_if.Busy}, 32'd0);
        chk("reset Done", {31'd0, bus_if.Done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            start_op(vt[i].fs, vt[i].wf, vt[i].a, vt[i].b);
            chk($sformatf("vec%0d result", i), bus_if.ALUOut, vt[i].exp_r);
            chk($sformatf("vec%0d flags", i), {28'd0, bus_if.FlagsOut}, {28'd0, vt[i].exp_f});
            chk($sformatf("vec%0d done", i), {30'd0, bus_if.Busy, bus_if.Done}, 32'd1);
        end

        run_iter("mul_ignore_start", 6'd16, 1'b1, 32'h00010000, 32'h00010000,
                 32'h00000000, 4'b1100, 1'b1);
        @(negedge clk);
        chk("mul done pulse ends", {30'd0, bus_if.Busy, bus_if.Done}, 32'd0);
        chk("mul ignored start result", bus_if.ALUOut, 32'h00000000);

        run_iter("mulh_ff", 6'd17, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 4'b0110, 1'b0);
        run_iter("mul_ff", 6'h30, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h00000001, 4'b0100, 1'b0);
        run_iter("mul_nowf", 6'd16, 1'b0, 32'd3, 32'd5, 32'd15, 4'b0100, 1'b0);

`ifdef SEQ_ALU_DIV_EN
        run_iter("divu", 6'd18, 1'b1, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b0);
        run_iter("remu", 6'd19, 1'b1, 32'd100, 32'd7, 32'd2, 4'b0000, 1'b0);
        run_iter("divu_by0", 6'd18, 1'b1, 32'd100, 32'd0, 32'hFFFFFFFF, 4'b0110, 1'b0);
        run_iter("remu_by0", 6'd19, 1'b1, 32'd100, 32'd0, 32'd100, 4'b0100, 1'b0);
`else
        start_op(6'd18, 1'b1, 32'd100, 32'd7);
        chk("div reserved busy_done", {30'd0, bus_if.Busy, bus_if.Done}, 32'd1);
        chk("div reserved result", bus_if.ALUOut, 32'd0);
        chk("div reserved flags", {28'd0, bus_if.FlagsOut}, 32'b0100);
`endif

        start_op(6'd0, 1'b1, 32'hDEADBEEF, 32'd0);
        chk("pre-reset result", bus_if.ALUOut, 32'hDEADBEEF);
        chk("pre-reset flags", {28'd0, bus_if.FlagsOut}, 32'b0110);

        start_op(6'd16, 1'b1, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort ALUOut", bus_if.ALUOut, 32'd0);
        chk("abort FlagsOut", {28'd0, bus_if.FlagsOut}, 32'd0);
        chk("abort Busy", {31'd0, bus_if.Busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_if.Done || bus_if.Busy) done_busy++;
        end
        chk("abort no later done", done_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
